// File: rtl/fpu_mult_arbiter_if.sv
// Signal bundle between fpu_mult_arbiter, its requesters and the shared FP16 FMA unit.
// Handshake: a transfer happens on a rising edge where valid and ready are both high. Valid never
// waits for ready. req_ready is combinational from req_valid. rsp_valid holds until rsp_ready.
interface fpu_mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*3*WIDTH-1:0] req_operands;
    logic [3*WIDTH-1:0]       fpu_operands;
    logic                     fpu_in_valid;
    logic [WIDTH-1:0]         fpu_result;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [N_REQ*WIDTH-1:0]   rsp_result;
    logic                     busy;
    logic [PW-1:0]            dbg_rr_ptr;
    logic [N_REQ-1:0]         dbg_pending;

    modport slave (
        input  req_valid, req_operands, rsp_ready, fpu_result,
        output req_ready, fpu_operands, fpu_in_valid, rsp_valid, rsp_result, busy,
               dbg_rr_ptr, dbg_pending
    );

    modport master (
        output req_valid, req_operands, rsp_ready, fpu_result,
        input  req_ready, fpu_operands, fpu_in_valid, rsp_valid, rsp_result, busy,
               dbg_rr_ptr, dbg_pending
    );
endinterface

// File: rtl/fpu_mult_arbiter.sv
// Round-robin sharing of one pipelined FP16 FMA unit among N_REQ requesters, with a tag
// pipeline that steers each result into the issuing requester's held response slot.
module fpu_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 3
) (
    input logic              clk,
    input logic              rst,
    fpu_mult_arbiter_if.slave bus
);
    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OPW = 3 * WIDTH;

    logic [N_REQ-1:0]       pending;
    logic [N_REQ-1:0]       eligible;
    logic [2*N_REQ-1:0]     eligible_dbl;
    logic [N_REQ-1:0]       eligible_rot;
    logic [N_REQ-1:0]       grant;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          rr_next;
    logic [PW-1:0]          grant_idx;
    logic                   hs;
    logic [OPW-1:0]         grant_ops;
    int                     sum;

    logic [OPW-1:0]         fpu_ops_q;
    logic                   fpu_vld_q;
    logic [PW-1:0]          issue_idx;

    logic [LATENCY-1:0]     tag_v;
    logic [PW-1:0]          tag_idx [LATENCY];

    logic [N_REQ-1:0]       rsp_valid_q;
    logic [N_REQ*WIDTH-1:0] rsp_result_q;
    logic [N_REQ-1:0]       rsp_hs;

    // Gating with rst keeps req_ready at 0 while reset is held, even if requesters stay valid.
    assign eligible     = bus.req_valid & ~pending & {N_REQ{~rst}};
    assign eligible_dbl = {eligible, eligible};
    assign eligible_rot = eligible_dbl[rr_ptr +: N_REQ];
    assign rsp_hs       = rsp_valid_q & bus.rsp_ready;

    // eligible_rot[0] is the requester at rr_ptr; the lowest set bit wins.
    always_comb begin
        hs        = 1'b0;
        grant_idx = '0;
        grant     = '0;
        grant_ops = '0;
        sum       = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible_rot[i]) begin
                hs  = 1'b1;
                sum = int'(rr_ptr) + i;
            end
        end
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        grant_idx = PW'(sum);
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = hs && (grant_idx == PW'(i));
            if (grant[i]) begin
                grant_ops = bus.req_operands[i*OPW +: OPW];
            end
        end
        rr_next = rr_ptr;
        if (hs) begin
            rr_next = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            rr_ptr    <= '0;
            fpu_vld_q <= 1'b0;
            fpu_ops_q <= '0;
            issue_idx <= '0;
        end else begin
            pending   <= (pending | grant) & ~rsp_hs;
            rr_ptr    <= rr_next;
            fpu_vld_q <= hs;
            if (hs) begin
                fpu_ops_q <= grant_ops;
                issue_idx <= grant_idx;
            end
        end
    end

    // Tags travel alongside the FPU pipeline so the last stage lines up with fpu_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_v[0]   <= fpu_vld_q;
            tag_idx[0] <= issue_idx;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // A slot cannot capture and hand off in the same cycle: pending blocks reissue until handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_hs[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
                if (tag_v[LATENCY-1] && (tag_idx[LATENCY-1] == PW'(i))) begin
                    rsp_valid_q[i]                 <= 1'b1;
                    rsp_result_q[i*WIDTH +: WIDTH] <= bus.fpu_result;
                end
            end
        end
    end

    assign bus.req_ready    = grant;
    assign bus.fpu_operands = fpu_ops_q;
    assign bus.fpu_in_valid = fpu_vld_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.busy         = |pending;
    assign bus.dbg_rr_ptr   = rr_ptr;
    assign bus.dbg_pending  = pending;
endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Bench for fpu_mult_arbiter: behavioural FMA pipeline, cycle-level arbitration/response model
// checked every cycle, plus directed scenario tasks.
module tb_fpu_mult_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 3;
    localparam int OPW = 3 * W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    fpu_mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fpu_mult_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- FP16 helpers (exact values only) ----------------
    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        int  ex;
        e = int'(h[14:10]);
        v = real'(int'(h[9:0]));
        if (e == 0) begin
            ex = -24;
        end else begin
            v  = v + 1024.0;
            ex = e - 25;
        end
        while (ex > 0) begin v = v * 2.0; ex--; end
        while (ex < 0) begin v = v / 2.0; ex++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real  v;
        logic s;
        int   e;
        int   m;
        s = (x < 0.0);
        v = s ? -x : x;
        if (v == 0.0) return {s, 15'b0};
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = $rtoi((v - 1.0) * 1024.0 + 0.5);
        return {s, e[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] fma(input logic [OPW-1:0] ops);
        return r2h(h2r(ops[15:0]) * h2r(ops[31:16]) + h2r(ops[47:32]));
    endfunction

    function automatic logic [OPW-1:0] rand_ops();
        logic [15:0] a, b, c;
        a = r2h(real'($urandom_range(0, 15)));
        b = r2h(real'($urandom_range(0, 15)));
        c = r2h(real'($urandom_range(0, 15)));
        return {c, b, a};
    endfunction

    // ---------------- behavioural FPU pipeline ----------------
    logic [W-1:0] fpu_pipe [L];
    always @(posedge clk) begin
        fpu_pipe[0] <= fma(bus.fpu_operands);
        for (int s = 1; s < L; s++) fpu_pipe[s] <= fpu_pipe[s-1];
    end
    assign bus.fpu_result = fpu_pipe[L-1];

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0]   exp_q [N][$];
    logic [N-1:0]   m_pending;
    logic [N-1:0]   m_rsp_valid;
    int             m_ptr;
    int             m_due [N];
    bit             m_prev_grant;
    logic [OPW-1:0] m_prev_ops;
    int             exp_g;
    logic [N-1:0]   exp_ready;
    logic [W-1:0]   e_res;
    logic [OPW-1:0] g_ops;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bus.req_ready !== '0 || bus.fpu_in_valid !== 1'b0 || bus.rsp_valid !== '0 ||
                bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL mon_in_reset: got ready=%b fiv=%b rsp_valid=%b busy=%b, required all 0",
                         bus.req_ready, bus.fpu_in_valid, bus.rsp_valid, bus.busy);
            end
            m_pending    = '0;
            m_rsp_valid  = '0;
            m_ptr        = 0;
            m_prev_grant = 0;
            for (int i = 0; i < N; i++) begin
                m_due[i] = -1;
                exp_q[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_due[i] == cyc) begin
                    m_rsp_valid[i] = 1'b1;
                    m_due[i]       = -1;
                end
            end
            exp_g = -1;
            for (int k = 0; k < N; k++) begin
                if (exp_g < 0 && bus.req_valid[(m_ptr + k) % N] && !m_pending[(m_ptr + k) % N])
                    exp_g = (m_ptr + k) % N;
            end
            exp_ready = '0;
            if (exp_g >= 0) exp_ready[exp_g] = 1'b1;

            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL mon_req_ready at cyc %0d: got %b required %b", cyc, bus.req_ready, exp_ready);
            end
            checks++;
            if (bus.fpu_in_valid !== m_prev_grant) begin
                errors++;
                $display("FAIL mon_fpu_in_valid at cyc %0d: got %b required %b", cyc, bus.fpu_in_valid, m_prev_grant);
            end
            if (m_prev_grant) begin
                checks++;
                if (bus.fpu_operands !== m_prev_ops) begin
                    errors++;
                    $display("FAIL mon_fpu_operands at cyc %0d: got %h required %h", cyc, bus.fpu_operands, m_prev_ops);
                end
            end
            checks++;
            if (bus.rsp_valid !== m_rsp_valid) begin
                errors++;
                $display("FAIL mon_rsp_valid at cyc %0d: got %b required %b", cyc, bus.rsp_valid, m_rsp_valid);
            end
            checks++;
            if (bus.busy !== (|m_pending)) begin
                errors++;
                $display("FAIL mon_busy at cyc %0d: got %b required %b", cyc, bus.busy, |m_pending);
            end
            for (int i = 0; i < N; i++) begin
                if (m_rsp_valid[i] && bus.rsp_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL mon_rsp_result slot %0d at cyc %0d: got %h required nothing queued",
                                 i, cyc, bus.rsp_result[i*W +: W]);
                    end else begin
                        e_res = exp_q[i].pop_front();
                        if (bus.rsp_result[i*W +: W] !== e_res) begin
                            errors++;
                            $display("FAIL mon_rsp_result slot %0d at cyc %0d: got %h required %h",
                                     i, cyc, bus.rsp_result[i*W +: W], e_res);
                        end
                    end
                    m_rsp_valid[i] = 1'b0;
                    m_pending[i]   = 1'b0;
                end
            end
            m_prev_grant = 0;
            if (exp_g >= 0) begin
                g_ops = bus.req_operands[exp_g*OPW +: OPW];
                exp_q[exp_g].push_back(fma(g_ops));
                m_due[exp_g]     = cyc + 2 + L;
                m_pending[exp_g] = 1'b1;
                m_ptr            = (exp_g + 1) % N;
                m_prev_grant     = 1;
                m_prev_ops       = g_ops;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_operands = '0;
        bus.rsp_ready    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
        checks++; if (bus.fpu_in_valid !== 1'b0) begin errors++; $display("FAIL reset_fpu_in_valid: got %b required 0", bus.fpu_in_valid); end
        checks++; if (bus.fpu_operands !== '0) begin errors++; $display("FAIL reset_fpu_operands: got %h required 0", bus.fpu_operands); end
        checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result: got %h required 0", bus.rsp_result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.dbg_rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr: got %0d required 0", bus.dbg_rr_ptr); end
        tick();
    endtask

    task automatic test_single_op();
        logic [OPW-1:0] ops;
        ops = {16'h3C00, 16'h4000, 16'h3C00};
        bus.rsp_ready          = '1;
        bus.req_operands[0 +: OPW] = ops;
        bus.req_valid          = 4'b0001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready: got %b required 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.fpu_in_valid !== 1'b1) begin errors++; $display("FAIL single_fpu_in_valid: got %b required 1", bus.fpu_in_valid); end
        checks++; if (bus.fpu_operands !== ops) begin errors++; $display("FAIL single_fpu_operands: got %h required %h", bus.fpu_operands, ops); end
        for (int c = 2; c <= 1 + L; c++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL single_early_rsp cycle +%0d: got %b required 0", c, bus.rsp_valid); end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b required 0001", bus.rsp_valid); end
        checks++; if (bus.rsp_result[0 +: W] !== 16'h4200) begin errors++; $display("FAIL single_rsp_result: got %h required 4200", bus.rsp_result[0 +: W]); end
        tick();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b required 0", bus.busy); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [W-1:0]   exp_r [N];
        logic [OPW-1:0] ops;
        do_reset();
        bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            ops = rand_ops();
            bus.req_operands[i*OPW +: OPW] = ops;
            exp_r[i] = fma(ops);
        end
        bus.req_valid = '1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== (4'b0001 << k)) begin errors++; $display("FAIL rr_grant_%0d: got %b required %b", k, bus.req_ready, 4'b0001 << k); end
            tick();
            bus.req_valid[k] = 1'b0;
        end
        for (int c = N; c < 2 + L; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL rr_early_rsp: got %b required 0", bus.rsp_valid); end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== (4'b0001 << k)) begin errors++; $display("FAIL rr_rsp_order_%0d: got %b required %b", k, bus.rsp_valid, 4'b0001 << k); end
            checks++; if (bus.rsp_result[k*W +: W] !== exp_r[k]) begin errors++; $display("FAIL rr_rsp_result_%0d: got %h required %h", k, bus.rsp_result[k*W +: W], exp_r[k]); end
            tick();
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rsp_ready = 4'b1101;
        bus.req_operands[1*OPW +: OPW] = {16'h3800, 16'h4200, 16'h4000};
        bus.req_operands[2*OPW +: OPW] = rand_ops();
        bus.req_valid = 4'b0110;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b required 0010", bus.req_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b required 0100", bus.req_ready); end
        tick();
        bus.req_valid[2] = 1'b0;
        for (int c = 2; c < 2 + L + 10; c++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL bp_no_regrant cycle +%0d: got %b required 0", c, bus.req_ready); end
            if (c >= 2 + L) begin
                checks++; if (bus.rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_rsp_held cycle +%0d: got %b required 1", c, bus.rsp_valid[1]); end
                checks++; if (bus.rsp_result[1*W +: W] !== 16'h4680) begin errors++; $display("FAIL bp_result_held cycle +%0d: got %h required 4680", c, bus.rsp_result[1*W +: W]); end
            end
            tick();
        end
        bus.rsp_ready[1] = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL bp_same_cycle_regrant: got %b required 0", bus.req_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_regrant: got %b required 0010", bus.req_ready); end
        checks++; if (bus.rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_rsp_cleared: got %b required 0", bus.rsp_valid[1]); end
        checks++; if (bus.rsp_result[1*W +: W] !== 16'h4680) begin errors++; $display("FAIL bp_result_after_accept: got %h required 4680", bus.rsp_result[1*W +: W]); end
        tick();
        bus.req_valid = '0;
        repeat (L + 4) tick();
    endtask

    task automatic test_fairness_skip();
        do_reset();
        bus.rsp_ready = '1;
        bus.req_operands[1*OPW +: OPW] = rand_ops();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL skip_setup_grant: got %b required 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        repeat (L + 4) tick();
        @(negedge clk);
        checks++; if (bus.dbg_rr_ptr !== 2'd2) begin errors++; $display("FAIL skip_ptr_start: got %0d required 2", bus.dbg_rr_ptr); end
        tick();
        bus.req_operands[0*OPW +: OPW] = rand_ops();
        bus.req_operands[3*OPW +: OPW] = rand_ops();
        bus.req_valid = 4'b1001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first_grant: got %b required 1000", bus.req_ready); end
        tick();
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL skip_second_grant: got %b required 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL skip_ptr_end: got %0d required 1", bus.dbg_rr_ptr); end
        tick();
        repeat (L + 4) tick();
    endtask

    task automatic test_reset_mid();
        logic [OPW-1:0] ops;
        do_reset();
        bus.rsp_ready = '1;
        bus.req_operands[0*OPW +: OPW] = rand_ops();
        bus.req_operands[1*OPW +: OPW] = rand_ops();
        bus.req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant0: got %b required 0001", bus.req_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant1: got %b required 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.fpu_in_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got fiv=%b busy=%b required 1 1", bus.fpu_in_valid, bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.fpu_in_valid !== 1'b0) begin errors++; $display("FAIL mid_async_fiv: got %b required 0", bus.fpu_in_valid); end
        checks++; if (bus.fpu_operands !== '0) begin errors++; $display("FAIL mid_async_ops: got %h required 0", bus.fpu_operands); end
        checks++; if (bus.busy !== 1'b0 || bus.dbg_pending !== '0) begin errors++; $display("FAIL mid_async_busy: got busy=%b pending=%b required 0", bus.busy, bus.dbg_pending); end
        checks++; if (bus.rsp_valid !== '0 || bus.req_ready !== '0) begin errors++; $display("FAIL mid_async_rsp: got rsp_valid=%b ready=%b required 0", bus.rsp_valid, bus.req_ready); end
        checks++; if (bus.dbg_rr_ptr !== '0) begin errors++; $display("FAIL mid_async_ptr: got %0d required 0", bus.dbg_rr_ptr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2 * L; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== '0) begin errors++; $display("FAIL mid_stale_rsp +%0d: got %b required 0", c, bus.rsp_valid); end
            tick();
        end
        ops = rand_ops();
        bus.req_operands[2*OPW +: OPW] = ops;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_fresh_grant: got %b required 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        for (int c = 1; c <= 1 + L; c++) tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL mid_fresh_rsp_valid: got %b required 0100", bus.rsp_valid); end
        checks++; if (bus.rsp_result[2*W +: W] !== fma(ops)) begin errors++; $display("FAIL mid_fresh_result: got %h required %h", bus.rsp_result[2*W +: W], fma(ops)); end
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] hs_s;
        do_reset();
        hs_s = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || hs_s[i]) begin
                    bus.req_valid[i]               = ($urandom_range(0, 99) < 40);
                    bus.req_operands[i*OPW +: OPW] = rand_ops();
                end
            end
            bus.rsp_ready = N'($urandom_range(0, (1 << N) - 1));
            @(negedge clk);
            hs_s = bus.req_ready;
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (L + 6) tick();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin errors++; $display("FAIL random_drain: got busy=%b rsp_valid=%b required 0", bus.busy, bus.rsp_valid); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks           = 0;
        errors           = 0;
        cyc              = 0;
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_operands = '0;
        bus.rsp_ready    = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_fairness_skip();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_mult_arbiter.md
# fpu_mult_arbiter

Round-robin arbiter that shares one pipelined FP16 fused multiply-add unit (`fpu_wrapper`, three 16-bit operands, one 16-bit result, fixed pipeline depth) among `N_REQ` requesters. Each requester has a valid/ready request port and a valid/ready response port. The block issues at most one operation per cycle and carries the requester index down a tag pipeline that matches the FPU depth. It routes each result back to the issuing requester and holds it until that requester accepts it. It sits between the requester-side `dut_if` handshakes and the FPU instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand/result width (FP16).
- `LATENCY`, 3: FPU pipeline depth in cycles, ≥1. `fpu_result` for an operation presented in cycle c is valid in cycle c+LATENCY.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  request valid per requester.
- `req_ready`  out  N_REQ  grant; one-hot or zero, combinational.
- `req_operands`  in  N_REQ*3*WIDTH  requester i operands at [i*3*WIDTH +: 3*WIDTH]; op0 is in the low WIDTH bits.
- `fpu_operands`  out  3*WIDTH  registered operands to the FPU.
- `fpu_in_valid`  out  1  `fpu_operands` hold a real operation this cycle.
- `fpu_result`  in  WIDTH  FPU output.
- `rsp_valid`  out  N_REQ  result held for requester i.
- `rsp_ready`  in  N_REQ  requester i accepts its result.
- `rsp_result`  out  N_REQ*WIDTH  result slot i at [i*WIDTH +: WIDTH].
- `busy`  out  1  OR of all `pending` bits.

## Operation
- **Per-requester `pending[i]`**
  - Set at the grant edge for requester i.
  - Cleared at the edge where `rsp_valid[i] && rsp_ready[i]`.
  - Limits each requester to one outstanding operation, so result slot i is never overwritten.
- **Eligibility:** requester i is eligible when `req_valid[i] && !pending[i]`.
- **Arbitration**
  - Round-robin pointer `rr_ptr` (log2 N_REQ bits, reset 0).
  - The grant goes to the first eligible index scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - `req_ready[g]=1` only for that index; all others are 0.
  - If none is eligible, `req_ready` = 0.
  - After a handshake with index g, `rr_ptr` ← (g+1) mod N_REQ. With no handshake, `rr_ptr` holds.
- **Issue register**
  - On handshake: `fpu_operands` ← `req_operands[g]` and `fpu_in_valid` ← 1.
  - Otherwise: `fpu_in_valid` ← 0 and `fpu_operands` hold.
- **Tag pipeline**
  - LATENCY stages of {valid, index}. Stage 0 loads {`fpu_in_valid`, issue index} every cycle.
  - When the last stage is valid with index k: `rsp_result[k]` ← `fpu_result` and `rsp_valid[k]` ← 1.
- **Response**
  - `rsp_valid[i]` clears at the edge where `rsp_ready[i]` is sampled high.
  - `rsp_result[i]` holds its value after that.
  - Responses for different requesters are independent and may complete in the same cycle.
- **Simultaneous events**
  - A response handshake and a new request from the same requester in the same cycle: no grant that cycle, because `pending` is still set. The earliest re-grant is the next cycle.
  - A capture into slot k and a handshake on slot j≠k in the same cycle: both take effect.
- **Reset:** asynchronous reset mid-operation discards all in-flight tags and held results. FPU outputs arriving after reset are ignored, because all tag valids are 0.

## Timing
- Reset values:
  - `req_ready`=0 (falls out of `pending`/`req_valid`).
  - `fpu_in_valid`=0, `fpu_operands`=0.
  - `rsp_valid`=0, `rsp_result`=0, `busy`=0.
  - `pending`=0, `rr_ptr`=0, all tag stages invalid.
- Request handshake in cycle t:
  - `fpu_in_valid`=1 in cycle t+1.
  - `fpu_result` is sampled in cycle t+1+LATENCY.
  - `rsp_valid` is high from cycle t+2+LATENCY.
- Latency from request handshake to response visible is LATENCY+2 cycles.
- Throughput: one issue per cycle while distinct requesters are eligible. A single requester can issue at most once per LATENCY+3 cycles if it sets `rsp_ready` as soon as `rsp_valid` rises.
- `busy` goes high the cycle after the first grant and low the cycle after the last response handshake.

## Test plan
- **Single op.** Reset, then requester 0 presents {0x3C00, 0x4000, 0x3C00} (1·2+1), with `rsp_ready[0]`=1.
  - Check `req_ready[0]` is high in the same cycle.
  - Check `fpu_in_valid` is high one cycle later.
  - Check `rsp_valid[0]` with `rsp_result`=0x4200 at t+2+LATENCY.
  - Check `busy` drops afterwards.
- **Round-robin.** All four requesters are valid continuously with `rsp_ready` high.
  - Grants must go in the order 0, 1, 2, 3 on consecutive cycles.
  - The responses must arrive at their own slots in the same order, one per cycle.
- **Backpressure.** Requester 1 sends {0x4000, 0x4200, 0x3800} (2·3+0.5) with `rsp_ready[1]`=0 for 10 cycles and `req_valid[1]` held.
  - `rsp_result[1]` must hold 0x4680.
  - There must be no second grant to requester 1 until one cycle after `rsp_ready[1]` rises.
  - Requester 2 must still be granted during the stall.
- **Fairness skip.** With `rr_ptr`=2, only requesters 0 and 3 are valid.
  - Requester 3 is granted first, then 0.
  - `rr_ptr` ends at 1.
- **Reset mid-flight.** Issue to requesters 0 and 1, then assert `rst` for 1 cycle before any result arrives.
  - All outputs must go to reset values immediately (asynchronous).
  - No `rsp_valid` may appear within 2·LATENCY cycles afterward.
  - A fresh request must then complete normally.
